memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly upstream of the write-back stage.
- Drives a req/ready/rvalid data-memory port and formats store byte-lanes and load sign/zero extension.
- Stalls upstream while an access is outstanding.
- Holds the MEM/WB pipeline register that supplies RegWriteW, ResultSrcW, RdW, PCPlus4W, ReadDataW and ALUResultW to write-back.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles from request to rvalid before abort; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RegWriteM  in  1  instruction writes rd.
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4.
- MemWriteM  in  1  store instruction.
- Funct3M  in  3  access size/sign.
- RdM  in  5  destination register.
- ALUResultM  in  32  effective address or ALU result.
- WriteDataM  in  32  store data (rs2).
- PCPlus4M  in  32  PC+4.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address {ALUResultM[31:2],2'b00}.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  request accepted this cycle.
- dmem_rvalid  in  1  access complete; rdata valid for loads.
- dmem_rdata  in  32  read word.
- StallM  out  1  hold IF/ID/EX and the M-stage inputs.
- RegWriteW  out  1  registered.
- ResultSrcW  out  2  registered.
- RdW  out  5  registered.
- PCPlus4W  out  32  registered.
- ReadDataW  out  32  registered, extended load data.
- ALUResultW  out  32  registered.
- MisalignW  out  1  registered one-cycle fault flag.
- BusErrW  out  1  registered one-cycle timeout flag.

Behaviour:
- Memory op (memop): MemWriteM=1 or ResultSrcM=01.
- Misaligned:
  - halfword with ALUResultM[0]=1;
  - word with ALUResultM[1:0]!=0.
- FSM states:
  - IDLE: a memop that is not misaligned asserts dmem_req combinationally. If dmem_ready=1, go to RESP, else go to REQ.
  - REQ: hold dmem_req and all dmem_* values until dmem_ready=1, then go to RESP.
  - RESP: dmem_req=0. On dmem_rvalid=1, capture and return to IDLE.
  - rvalid is never accepted in the same cycle as the request.
- StallM = memop & not misaligned & not (state==RESP & dmem_rvalid). It is combinational.
- Upstream holds the M inputs stable while StallM=1.
- Minimum memop latency: 2 cycles (ready in cycle 0, rvalid in cycle 1). Non-memops: 1 cycle, StallM=0.
- MEM/WB register, per rising edge:
  - StallM=1: load a bubble (RegWriteW=0, MisalignW=0, BusErrW=0; other W fields don't-care, held).
  - Otherwise: capture the M fields.
- Stores:
  - SB: be=4'b0001<<addr[1:0], wdata={4{WriteDataM[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{WriteDataM[15:0]}}.
  - SW: be=4'b1111.
  - dmem_we=MemWriteM.
  - Loads drive be=4'b1111, we=0.
- Loads: select the lane by addr[1:0] from dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Unused funct3 values behave as LW/SW.
- Misaligned memop:
  - no request, no stall;
  - registers normally with RegWriteW=0 and MisalignW=1.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter starts at 0 on request, counts each cycle in REQ/RESP, and clears in IDLE.
  - On reaching TIMEOUT_CYCLES without rvalid: abort to IDLE, deassert StallM, and register the instruction with RegWriteW=0, BusErrW=1.
  - Late rvalid arriving in IDLE is ignored.
- Reset (RESET=0, any time including mid-access), immediately:
  - state=IDLE, counter=0, dmem_req=0;
  - all W outputs 0 (RegWriteW=0, ResultSrcW=00, RdW=0, data fields 0, flags 0).
- Simultaneous: dmem_ready and dmem_rvalid both high in REQ. Treat as accept only; rvalid is ignored in that cycle.

Test Plan:
- ALU op: RegWriteM=1, ResultSrcM=00, RdM=5, ALUResultM=0x1234 -> next cycle RegWriteW=1, RdW=5, ALUResultW=0x1234; StallM=0 throughout.
- LB at addr 0x1003, rdata=0x80FF_0000, ready in cycle 0, rvalid in cycle 1 -> StallM=1 for cycle 0 only; ReadDataW=0xFFFF_FF80; RdW correct.
- LHU at 0x2002, rdata=0xBEEF_1234, ready held low 3 cycles, rvalid 2 cycles after accept -> dmem_req stable through 3+1 cycles; ReadDataW=0x0000_BEEF; one bubble W cycle per stall cycle.
- SB at 0x0101, WriteDataM=0xAABB_CCDD -> dmem_addr=0x100, be=0010, wdata=0xDDDD_DDDD, we=1; RegWriteW=0 after rvalid.
- LW at 0x0006 -> no dmem_req, StallM=0, next cycle MisalignW=1, RegWriteW=0.
- TIMEOUT_CYCLES=4, LW with ready=1, no rvalid -> abort after 4 cycles with BusErrW=1, RegWriteW=0. Separately, RESET low while in RESP -> dmem_req=0 and W outputs 0 immediately.

Source files
------------

// File: rtl/memory_stage_if.sv
// Data-memory request/response port between the MEM stage (master) and data memory (slave).
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// RV32I MEM stage: data-memory handshake, store lane formatting, load extension,
// access timeout and the MEM/WB pipeline register.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           RegWriteM,
    input  logic [1:0]     ResultSrcM,
    input  logic           MemWriteM,
    input  logic [2:0]     Funct3M,
    input  logic [4:0]     RdM,
    input  logic [31:0]    ALUResultM,
    input  logic [31:0]    WriteDataM,
    input  logic [31:0]    PCPlus4M,
    memory_stage_if.master dmem,
    output logic           StallM,
    output logic           RegWriteW,
    output logic [1:0]     ResultSrcW,
    output logic [4:0]     RdW,
    output logic [31:0]    PCPlus4W,
    output logic [31:0]    ReadDataW,
    output logic [31:0]    ALUResultW,
    output logic           MisalignW,
    output logic           BusErrW
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] waitCnt;
    logic             memOp;
    logic             isByte;
    logic             isHalf;
    logic             misalign;
    logic             goodOp;
    logic             rvalidTake;
    logic             timeout;
    logic             reqS;
    logic [3:0]       beS;
    logic [31:0]      wdataS;
    logic [31:0]      loadData;

    function automatic logic [31:0] extendLoad(input logic [2:0]  f3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extendLoad = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extendLoad = {{16{half[15]}}, half};
            3'b100:  extendLoad = {24'd0, shifted[7:0]};
            3'b101:  extendLoad = {16'd0, half};
            default: extendLoad = word;
        endcase
    endfunction

    // Access decode; store funct3 values beyond SW fall back to word size
    always_comb begin
        memOp  = MemWriteM | (ResultSrcM == 2'b01);
        isByte = (Funct3M[1:0] == 2'b00) & ~(MemWriteM & Funct3M[2]);
        isHalf = (Funct3M[1:0] == 2'b01) & ~(MemWriteM & Funct3M[2]);
        if (isHalf) begin
            misalign = memOp & ALUResultM[0];
        end else if (isByte) begin
            misalign = 1'b0;
        end else begin
            misalign = memOp & (ALUResultM[1:0] != 2'b00);
        end
        goodOp = memOp & ~misalign;
    end

    // Handshake control: request, completion, timeout abort and upstream stall
    always_comb begin
        rvalidTake = (state == RESP) & dmem.dmem_rvalid;
        if ((TIMEOUT_CYCLES != 32'd0) && (state != IDLE)) begin
            timeout = (waitCnt == CNT_W'(TIMEOUT_CYCLES)) & ~rvalidTake;
        end else begin
            timeout = 1'b0;
        end
        reqS   = RESET & ~timeout & (((state == IDLE) & goodOp) | (state == REQ));
        StallM = RESET & goodOp & ~rvalidTake & ~timeout;
    end

    // Store byte-lane formatting; loads always read the full word
    always_comb begin
        beS    = 4'b1111;
        wdataS = WriteDataM;
        if (MemWriteM && isByte) begin
            beS    = 4'b0001 << ALUResultM[1:0];
            wdataS = {4{WriteDataM[7:0]}};
        end else if (MemWriteM && isHalf) begin
            beS    = 4'b0011 << {ALUResultM[1], 1'b0};
            wdataS = {2{WriteDataM[15:0]}};
        end else begin
            beS    = 4'b1111;
            wdataS = WriteDataM;
        end
    end

    assign loadData        = extendLoad(Funct3M, ALUResultM[1:0], dmem.dmem_rdata);
    assign dmem.dmem_req   = reqS;
    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem.dmem_wdata = wdataS;
    assign dmem.dmem_be    = beS;

    // Access FSM; waitCnt holds the number of cycles elapsed since the request
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            waitCnt <= CNT_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    if (goodOp) begin
                        state   <= dmem.dmem_ready ? RESP : REQ;
                        waitCnt <= CNT_W'(1);
                    end else begin
                        state   <= IDLE;
                        waitCnt <= CNT_W'(0);
                    end
                end
                REQ: begin
                    if (timeout) begin
                        state   <= IDLE;
                        waitCnt <= CNT_W'(0);
                    end else begin
                        state   <= dmem.dmem_ready ? RESP : REQ;
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rvalidTake || timeout) begin
                        state   <= IDLE;
                        waitCnt <= CNT_W'(0);
                    end else begin
                        state   <= RESP;
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    waitCnt <= CNT_W'(0);
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the retiring instruction
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= 5'd0;
            PCPlus4W   <= 32'd0;
            ReadDataW  <= 32'd0;
            ALUResultW <= 32'd0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~misalign & ~timeout;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            ReadDataW  <= loadData;
            ALUResultW <= ALUResultM;
            MisalignW  <= misalign;
            BusErrW    <= timeout;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a per-instruction reference model.
module tb_memory_stage;
    localparam int TMO = 4;

    logic        CLK;
    logic        RESET;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;

    logic        StallM, RegWriteW, MisalignW, BusErrW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W, ReadDataW, ALUResultW;

    logic        StallM4, RegWriteW4, MisalignW4, BusErrW4;
    logic [1:0]  ResultSrcW4;
    logic [4:0]  RdW4;
    logic [31:0] PCPlus4W4, ReadDataW4, ALUResultW4;

    int nChecks = 0;
    int nFails  = 0;

    memory_stage_if bus ();
    memory_stage_if bus4 ();

    memory_stage dut (
        .CLK(CLK), .RESET(RESET), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .dmem(bus), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .PCPlus4W(PCPlus4W),
        .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    memory_stage #(.TIMEOUT_CYCLES(TMO)) dut4 (
        .CLK(CLK), .RESET(RESET), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .dmem(bus4), .StallM(StallM4),
        .RegWriteW(RegWriteW4), .ResultSrcW(ResultSrcW4), .RdW(RdW4), .PCPlus4W(PCPlus4W4),
        .ReadDataW(ReadDataW4), .ALUResultW(ALUResultW4), .MisalignW(MisalignW4), .BusErrW(BusErrW4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setInputs(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
        RdM = rd; ALUResultM = alu; WriteDataM = wd; PCPlus4M = $urandom;
    endtask

    // One instruction on the main DUT: memory accepts at cycle a, completes at cycle r (r > a).
    task automatic runMain(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] rdata, input int a, input int r);
        bit          memop, mis, live;
        int          size, off, done;
        logic [31:0] expBe, expWd, expRd, lane, pc;
        setInputs(rw, rs, mw, f3, rd, alu, wd);
        pc    = PCPlus4M;
        memop = mw || (rs == 2'b01);
        if (mw) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        off  = int'(alu % 32'd4);
        mis  = memop && ((alu % size) != 0);
        done = (memop && !mis) ? r : 0;
        if (!mw)            begin expBe = 32'hF; expWd = wd; end
        else if (size == 1) begin expBe = 32'd1 << off; expWd = (wd & 32'hFF) * 32'h0101_0101; end
        else if (size == 2) begin expBe = 32'd3 << ((off / 2) * 2); expWd = (wd & 32'hFFFF) * 32'h0001_0001; end
        else                begin expBe = 32'hF; expWd = wd; end
        if (size == 1) begin
            lane  = (rdata >> (8 * off)) & 32'hFF;
            expRd = (f3 == 3'd0 && lane >= 32'd128) ? lane - 32'd256 : lane;
        end else if (size == 2) begin
            lane  = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            expRd = (f3 == 3'd1 && lane >= 32'h8000) ? lane - 32'h10000 : lane;
        end else begin
            expRd = rdata;
        end
        for (int k = 0; k <= done; k++) begin
            live = memop && !mis && (k <= a);
            bus.dmem_ready  = memop && !mis && (k == a);
            bus.dmem_rvalid = (memop && !mis && k == r) || (k <= a && $urandom_range(0, 1) == 1);
            bus.dmem_rdata  = (k == r) ? rdata : $urandom;
            @(negedge CLK);
            checkVal("stall", StallM, k < done);
            checkVal("req", bus.dmem_req, live);
            if (live) begin
                checkVal("addr", bus.dmem_addr, alu & 32'hFFFF_FFFC);
                checkVal("we", bus.dmem_we, mw);
                checkVal("be", bus.dmem_be, expBe);
                if (mw) checkVal("wdata", bus.dmem_wdata, expWd);
            end
            if (k > 0) begin
                checkVal("bubble_rw", RegWriteW, 32'd0);
                checkVal("bubble_mis", MisalignW, 32'd0);
                checkVal("bubble_berr", BusErrW, 32'd0);
            end
            @(posedge CLK); #1;
        end
        bus.dmem_ready  = 1'b0;
        bus.dmem_rvalid = 1'b0;
        checkVal("RegWriteW", RegWriteW, rw && !mis);
        checkVal("ResultSrcW", ResultSrcW, rs);
        checkVal("RdW", RdW, rd);
        checkVal("PCPlus4W", PCPlus4W, pc);
        checkVal("ALUResultW", ALUResultW, alu);
        checkVal("MisalignW", MisalignW, mis);
        checkVal("BusErrW", BusErrW, 32'd0);
        if (!mw && rs == 2'b01 && !mis) checkVal("ReadDataW", ReadDataW, expRd);
    endtask

    // LW on the short-timeout DUT; a or r < 0 means ready / rvalid never arrives.
    task automatic runTmo(input int a, input int r, input logic [31:0] rdata);
        bit         ok;
        int         c;
        logic [4:0] rd;
        rd = 5'($urandom_range(1, 31));
        setInputs(1'b1, 2'b01, 1'b0, 3'd2, rd, 32'h0000_0100, 32'd0);
        ok = (a >= 0) && (a < TMO) && (r > a) && (r <= TMO);
        c  = ok ? r : TMO;
        for (int k = 0; k <= c; k++) begin
            bus4.dmem_ready  = (k == a);
            bus4.dmem_rvalid = (k == r);
            bus4.dmem_rdata  = rdata;
            @(negedge CLK);
            checkVal("t_stall", StallM4, k < c);
            if (k < c) checkVal("t_req", bus4.dmem_req, (a < 0) || (k <= a));
            @(posedge CLK); #1;
        end
        bus4.dmem_ready  = 1'b0;
        bus4.dmem_rvalid = 1'b1;
        checkVal("t_BusErrW", BusErrW4, !ok);
        checkVal("t_RegWriteW", RegWriteW4, ok);
        checkVal("t_RdW", RdW4, rd);
        if (ok) checkVal("t_ReadDataW", ReadDataW4, rdata);
        setInputs(1'b1, 2'b00, 1'b0, 3'd0, 5'd3, 32'h55, 32'd0);
        @(negedge CLK);
        checkVal("t_late_stall", StallM4, 32'd0);
        @(posedge CLK); #1;
        bus4.dmem_rvalid = 1'b0;
        checkVal("t_berr_clear", BusErrW4, 32'd0);
        checkVal("t_next_rw", RegWriteW4, 32'd1);
    endtask

    initial begin
        logic [2:0] f3;
        int         t, a;
        RESET = 1'b1;
        setInputs(1'b0, 2'b00, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
        bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
        bus4.dmem_ready = 1'b1; bus4.dmem_rvalid = 1'b0; bus4.dmem_rdata = 32'd0;
        #1 RESET = 1'b0;
        @(negedge CLK);
        checkVal("rst_req", bus.dmem_req, 32'd0);
        checkVal("rst_rw", RegWriteW, 32'd0);
        checkVal("rst_rd", RdW, 32'd0);
        checkVal("rst_alu", ALUResultW, 32'd0);
        checkVal("rst_pc", PCPlus4W, 32'd0);
        checkVal("rst_flags", {MisalignW, BusErrW, ResultSrcW}, 32'd0);
        @(posedge CLK); #1 RESET = 1'b1;

        runMain(1'b1, 2'b00, 1'b0, 3'd0, 5'd5, 32'h1234, $urandom, $urandom, 0, 1);
        runMain(1'b1, 2'b01, 1'b0, 3'd0, 5'd10, 32'h1003, 32'd0, 32'h80FF_0000, 0, 1);
        runMain(1'b1, 2'b01, 1'b0, 3'd5, 5'd11, 32'h2002, 32'd0, 32'hBEEF_1234, 3, 5);
        runMain(1'b0, 2'b00, 1'b1, 3'd0, 5'd0, 32'h0101, 32'hAABB_CCDD, $urandom, 0, 1);
        runMain(1'b1, 2'b01, 1'b0, 3'd2, 5'd12, 32'h0006, 32'd0, $urandom, 0, 1);

        for (int i = 0; i < 80; i++) begin
            t  = $urandom_range(0, 2);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 3);
            case (t)
                0:       runMain(1'b1, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, 1'b0, f3,
                                 5'($urandom), $urandom, $urandom, $urandom, a, a + 1);
                1:       runMain(1'b1, 2'b01, 1'b0, f3, 5'($urandom), $urandom, $urandom, $urandom,
                                 a, a + $urandom_range(1, 3));
                default: runMain(1'b0, 2'b00, 1'b1, f3, 5'($urandom), $urandom, $urandom, $urandom,
                                 a, a + $urandom_range(1, 3));
            endcase
        end

        runMain(1'b1, 2'b00, 1'b0, 3'd0, 5'd7, 32'hCAFE, 32'd0, 32'd0, 0, 1);
        setInputs(1'b1, 2'b01, 1'b0, 3'd2, 5'd9, 32'h40, 32'd0);
        bus.dmem_ready = 1'b1;
        @(posedge CLK); #1;
        bus.dmem_ready = 1'b0;
        @(negedge CLK);
        checkVal("resp_req", bus.dmem_req, 32'd0);
        checkVal("resp_stall", StallM, 32'd1);
        #1 RESET = 1'b0;
        #1;
        checkVal("midrst_req", bus.dmem_req, 32'd0);
        checkVal("midrst_rw", RegWriteW, 32'd0);
        checkVal("midrst_rd", RdW, 32'd0);
        checkVal("midrst_alu", ALUResultW, 32'd0);
        checkVal("midrst_pc", PCPlus4W, 32'd0);
        checkVal("midrst_src", ResultSrcW, 32'd0);
        setInputs(1'b0, 2'b00, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
        @(posedge CLK); #1 RESET = 1'b1;
        runMain(1'b1, 2'b10, 1'b0, 3'd0, 5'd4, 32'h77, 32'd0, 32'd0, 0, 1);

        bus4.dmem_ready = 1'b0;
        runTmo(0, -1, 32'h1111_2222);
        runTmo(0, TMO, 32'h3333_4444);
        runTmo(-1, -1, 32'h5555_6666);
        runTmo(1, 3, 32'h7777_8888);
        runTmo(3, TMO + 1, 32'h9999_AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
